// File: rtl/sha256_msg_ctrl_if.sv
// Message input stream between a word source and sha256_msg_ctrl.
//   in_data  : 32-bit message word, first byte in [31:24]
//   in_valid : in_data is valid this cycle
//   in_ready : controller takes the word on this cycle's rising edge
//   in_last  : this is the final message beat
//   in_bytes : valid bytes (0..4, MSB-aligned) in the final beat
interface sha256_msg_ctrl_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [2:0]  in_bytes;

  modport master (output in_data, in_valid, in_last, in_bytes, input in_ready);
  modport slave  (input in_data, in_valid, in_last, in_bytes, output in_ready);
endinterface

// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message front-end and core sequencer.
// Takes a big-endian word stream, appends the 0x80 marker, zero padding and
// the 64-bit bit-length, buffers each 512-bit block and pushes it into the
// core (soc pulse, 16 contiguous words, wait for eoc). After the final block
// the eight hash words are read back through core_rd into hash_o.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : begin a new message / drop the current one
//   in_if             : message stream (slave side)
//   core_data_o/_oe   : word toward the core bus and its drive enable
//   core_data_i       : core bus as sampled (hash readback)
//   core_soc/rd/rst   : core start, read enable and reset
//   core_eoc          : core end-of-compression
//   busy, hash_o, hash_valid, err : status and digest (H0 in [255:224])
module sha256_msg_ctrl #(
  parameter int LEN_W   = 64,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  sha256_msg_ctrl_if.slave        in_if,
  output logic [31:0]             core_data_o,
  output logic                    core_data_oe,
  input  logic [31:0]             core_data_i,
  output logic                    core_soc,
  output logic                    core_rd,
  input  logic                    core_eoc,
  output logic                    core_rst,
  output logic                    busy,
  output logic [255:0]            hash_o,
  output logic                    hash_valid,
  output logic                    err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SOC, S_FEED, S_WAIT, S_READ, S_DONE
  } state_e;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;          // buffer index in FILL/FEED, hash index in READ
  logic [LEN_W-1:0]   len_q, len_d;
  logic               msg_done_q, msg_done_d;       // last beat taken, now padding
  logic               marker_done_q, marker_done_d; // 0x80 marker already written
  logic               final_blk_q, final_blk_d;     // current block carries the length
  logic               err_q, err_d;
  logic               core_rst_q, core_rst_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0]        buf_q [16];
  logic [31:0]        hash_q [8];

  logic        buf_we;
  logic [31:0] buf_wdata;
  logic        hash_we;
  logic        hash_clr;
  logic [2:0]  nb;
  logic [63:0] len_ext;

  function automatic logic [31:0] mask_last(input logic [31:0] d, input logic [2:0] n);
    case (n)
      3'd0:    return 32'h8000_0000;
      3'd1:    return {d[31:24], 24'h80_0000};
      3'd2:    return {d[31:16], 16'h8000};
      3'd3:    return {d[31:8], 8'h80};
      default: return d;
    endcase
  endfunction

  assign nb      = (in_if.in_bytes > 3'd4) ? 3'd4 : in_if.in_bytes;
  assign len_ext = 64'(len_q);

  assign in_if.in_ready = (state_q == S_FILL) && !msg_done_q;
  assign core_soc       = (state_q == S_SOC);
  assign core_data_oe   = (state_q == S_FEED);
  assign core_data_o    = core_data_oe ? buf_q[idx_q] : 32'h0;
  assign core_rd        = (state_q == S_READ);
  assign busy           = state_q inside {S_FILL, S_SOC, S_FEED, S_WAIT, S_READ};
  assign hash_valid     = (state_q == S_DONE) && !err_q;
  assign err            = err_q;
  assign core_rst       = rst | core_rst_q;
  assign hash_o = {hash_q[0], hash_q[1], hash_q[2], hash_q[3],
                   hash_q[4], hash_q[5], hash_q[6], hash_q[7]};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    len_d         = len_q;
    msg_done_d    = msg_done_q;
    marker_done_d = marker_done_q;
    final_blk_d   = final_blk_q;
    err_d         = err_q;
    core_rst_d    = 1'b0;
    wait_cnt_d    = wait_cnt_q;
    buf_we        = 1'b0;
    buf_wdata     = 32'h0;
    hash_we       = 1'b0;
    hash_clr      = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_FILL;
          idx_d         = 4'd0;
          len_d         = '0;
          msg_done_d    = 1'b0;
          marker_done_d = 1'b0;
          final_blk_d   = 1'b0;
          err_d         = 1'b0;
          hash_clr      = 1'b1;
        end
      end
      S_FILL: begin
        if (!msg_done_q) begin
          if (in_if.in_valid) begin
            buf_we = 1'b1;
            if (in_if.in_last) begin
              msg_done_d = 1'b1;
              len_d      = len_q + LEN_W'({nb, 3'b000});
              buf_wdata  = mask_last(in_if.in_data, nb);
              // A full last word leaves the marker for the pad phase.
              if (nb != 3'd4) begin
                marker_done_d = 1'b1;
                final_blk_d   = (idx_q <= 4'd13);
              end
            end else begin
              len_d     = len_q + LEN_W'(32);
              buf_wdata = in_if.in_data;
            end
          end
        end else begin
          buf_we = 1'b1;
          if (!marker_done_q) begin
            buf_wdata     = 32'h8000_0000;
            marker_done_d = 1'b1;
            final_blk_d   = (idx_q <= 4'd13);
          end else if (final_blk_q && idx_q == 4'd14) begin
            buf_wdata = len_ext[63:32];
          end else if (final_blk_q && idx_q == 4'd15) begin
            buf_wdata = len_ext[31:0];
          end
        end
        if (buf_we) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = S_SOC;
        end
      end
      S_SOC: state_d = S_FEED;
      S_FEED: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d    = S_WAIT;
          // Counts cycles since the last fed word, so the timeout fires
          // exactly TIMEOUT cycles after it.
          wait_cnt_d = WAIT_W'(1);
        end
      end
      S_WAIT: begin
        if (core_eoc) begin
          if (final_blk_q) begin
            state_d = S_READ;
          end else begin
            state_d = S_FILL;
            // Marker already placed in a non-final block: the next block
            // is the zero block that carries the length.
            final_blk_d = marker_done_q;
          end
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d    = S_DONE;
          err_d      = 1'b1;
          core_rst_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_READ: begin
        hash_we = 1'b1;
        idx_d   = idx_q + 4'd1;
        if (idx_q == 4'd7) begin
          idx_d   = 4'd0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      idx_d      = 4'd0;
      err_d      = 1'b0;
      core_rst_d = 1'b1;
      hash_clr   = 1'b1;
      buf_we     = 1'b0;
      hash_we    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values and updates together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= 4'd0;
      len_q         <= '0;
      msg_done_q    <= 1'b0;
      marker_done_q <= 1'b0;
      final_blk_q   <= 1'b0;
      err_q         <= 1'b0;
      core_rst_q    <= 1'b0;
      wait_cnt_q    <= '0;
      // NOTE: the block buffer and digest are flop arrays and are cleared
      // with the control state; a RAM-backed buffer would not be reset.
      for (int i = 0; i < 16; i++) buf_q[i] <= 32'h0;
      for (int i = 0; i < 8; i++) hash_q[i] <= 32'h0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      msg_done_q    <= msg_done_d;
      marker_done_q <= marker_done_d;
      final_blk_q   <= final_blk_d;
      err_q         <= err_d;
      core_rst_q    <= core_rst_d;
      wait_cnt_q    <= wait_cnt_d;
      if (buf_we) buf_q[idx_q] <= buf_wdata;
      if (hash_clr) begin
        for (int i = 0; i < 8; i++) hash_q[i] <= 32'h0;
      end else if (hash_we) begin
        hash_q[idx_q[2:0]] <= core_data_i;
      end
    end
  end

endmodule
